// File: rtl/branch_pred_unit.sv
// branch_pred_unit: dynamic branch predictor for the 5-stage pipeline.
// The BTB is direct-mapped and each entry holds a saturating counter. It is
// looked up in IF and trained in EX. The unit also counts resolved branches
// and mispredicts.
module branch_pred_unit #(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [31:0]       if_pc,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    input  logic              ex_valid,
    input  logic              ex_is_br,
    input  logic              ex_is_jump,
    input  logic [31:0]       ex_pc,
    input  logic              ex_taken,
    input  logic [31:0]       ex_target,
    input  logic              ex_pred_taken,
    input  logic [31:0]       ex_pred_target,
    output logic              mispredict,
    output logic [31:0]       redirect_pc,
    output logic [STAT_W-1:0] stat_br,
    output logic [STAT_W-1:0] stat_miss
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);

    // Prediction tables, one element per BTB entry.
    logic             valid_q   [ENTRIES];
    logic [CNT_W-1:0] cnt_q     [ENTRIES];
    logic [TAG_W-1:0] tag_q     [ENTRIES];
    logic [31:0]      target_q  [ENTRIES];
    logic             is_jump_q [ENTRIES];

    logic [STAT_W-1:0] stat_br_q, stat_br_d;
    logic [STAT_W-1:0] stat_miss_q, stat_miss_d;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit, ex_cf;
    logic             upd, wr_train, wr_alloc, wr_inval;
    logic [CNT_W-1:0] cnt_d;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[31:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[31:IDX_W+2];
    assign ex_cf  = ex_is_br | ex_is_jump;

    // IF lookup: the registered table is read before any update this cycle.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so that no path leaves it unassigned and infers a latch.
        pred_taken  = 1'b0;
        pred_target = if_pc + 32'd4;
        if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        if (if_hit && (is_jump_q[if_idx] || cnt_q[if_idx][CNT_W-1])) begin
            pred_taken  = 1'b1;
            pred_target = target_q[if_idx];
        end
    end

    // EX resolve: compare the actual outcome with the prediction that travelled with the instruction.
    always_comb begin
        mispredict  = 1'b0;
        redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;
        if (ex_valid) begin
            if (ex_cf) begin
                mispredict = (ex_taken != ex_pred_taken) ||
                             (ex_taken && (ex_target != ex_pred_target));
            end else begin
                // A non-branch predicted taken only aliased into the BTB.
                mispredict = ex_pred_taken;
            end
        end
    end

    // Decide which kind of table write the EX instruction causes.
    always_comb begin
        upd      = en && ex_valid;
        ex_hit   = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        wr_train = upd && ex_cf && ex_hit;
        wr_alloc = upd && ex_cf && !ex_hit && ex_taken;
        wr_inval = upd && !ex_cf && ex_hit;
        cnt_d    = cnt_q[ex_idx];
        if (wr_alloc) begin
            cnt_d = CNT_WT;
        end else if (ex_taken) begin
            if (cnt_q[ex_idx] != CNT_MAX) cnt_d = cnt_q[ex_idx] + CNT_W'(1);
        end else begin
            if (cnt_q[ex_idx] != '0) cnt_d = cnt_q[ex_idx] - CNT_W'(1);
        end
    end

    // Control state: valid bits and counters, cleared on reset.
    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments, so every
        // reader on this edge sees the pre-update value.
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= CNT_WNT;
            end
        end else begin
            if (wr_alloc) valid_q[ex_idx] <= 1'b1;
            if (wr_inval) valid_q[ex_idx] <= 1'b0;
            if (wr_alloc || wr_train) cnt_q[ex_idx] <= cnt_d;
        end
    end

    // Payload state: tag, target and jump flag of an allocated or trained entry.
    always_ff @(posedge clk) begin
        // NOTE: the payload arrays are deliberately not reset. An entry with
        // valid clear is never used, so the arrays can map onto plain RAM.
        if (!rst) begin
            if (wr_alloc) tag_q[ex_idx] <= ex_tag;
            if (wr_alloc || (wr_train && ex_taken)) target_q[ex_idx] <= ex_target;
            if (wr_alloc || wr_train) is_jump_q[ex_idx] <= ex_is_jump;
        end
    end

    // Statistic next-state: both counters wrap naturally.
    always_comb begin
        stat_br_d   = stat_br_q;
        stat_miss_d = stat_miss_q;
        if (upd && ex_cf) stat_br_d   = stat_br_q + STAT_W'(1);
        if (upd && mispredict) stat_miss_d = stat_miss_q + STAT_W'(1);
    end

    // Statistic registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_br_q   <= '0;
            stat_miss_q <= '0;
        end else begin
            stat_br_q   <= stat_br_d;
            stat_miss_q <= stat_miss_d;
        end
    end

    assign stat_br   = stat_br_q;
    assign stat_miss = stat_miss_q;

endmodule

// File: tb/tb_branch_pred_unit.sv
// tb_branch_pred_unit: directed scenarios followed by randomized traffic.
// Every cycle is checked against a table-level reference model.
module tb_branch_pred_unit;

    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;
    localparam int CNT_W   = 2;
    localparam int STAT_W  = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;
    localparam int CHALF   = 1 << (CNT_W - 1);
    localparam int SMOD    = 1 << STAT_W;

    logic              clk = 1'b0;
    logic              rst, en;
    logic [31:0]       if_pc;
    logic              pred_taken;
    logic [31:0]       pred_target;
    logic              ex_valid, ex_is_br, ex_is_jump, ex_taken, ex_pred_taken;
    logic [31:0]       ex_pc, ex_target, ex_pred_target;
    logic              mispredict;
    logic [31:0]       redirect_pc;
    logic [STAT_W-1:0] stat_br, stat_miss;

    int n_checks = 0;
    int n_errors = 0;

    branch_pred_unit #(.ENTRIES(ENTRIES), .CNT_W(CNT_W), .STAT_W(STAT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_is_br(ex_is_br), .ex_is_jump(ex_is_jump),
        .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .stat_br(stat_br), .stat_miss(stat_miss)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: one record per table slot, with the counter kept as a plain integer.
    bit          m_v   [ENTRIES];
    logic [31:0] m_tag [ENTRIES];
    logic [31:0] m_tgt [ENTRIES];
    bit          m_j   [ENTRIES];
    int          m_c   [ENTRIES];
    int          m_br, m_miss;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_v[m_idx(pc)] && (m_tag[m_idx(pc)] == (pc >> (IDX_W + 2)));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_j[m_idx(pc)] || m_c[m_idx(pc)] >= CHALF);
    endfunction

    function automatic logic [31:0] m_pred_tgt(input logic [31:0] pc);
        return m_pred(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_v[i] = 1'b0;
            m_c[i] = CHALF - 1;
        end
        m_br   = 0;
        m_miss = 0;
    endtask

    // Check all outputs against the model, clock once, and then advance the model.
    task automatic tick();
        bit          cf, exp_mp, hit;
        logic [31:0] exp_rd;
        int          i;
        #1;
        cf = ex_is_br || ex_is_jump;
        if (!ex_valid) exp_mp = 1'b0;
        else if (cf) exp_mp = (ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target);
        else exp_mp = ex_pred_taken;
        exp_rd = ex_taken ? ex_target : ex_pc + 32'd4;
        check("pred_taken", 32'(pred_taken), 32'(m_pred(if_pc)));
        check("pred_target", pred_target, m_pred_tgt(if_pc));
        check("mispredict", 32'(mispredict), 32'(exp_mp));
        check("redirect_pc", redirect_pc, exp_rd);
        check("stat_br", 32'(stat_br), 32'(m_br));
        check("stat_miss", 32'(stat_miss), 32'(m_miss));
        @(posedge clk);
        if (rst) begin
            m_reset();
        end else if (en && ex_valid) begin
            i   = m_idx(ex_pc);
            hit = m_hit(ex_pc);
            if (exp_mp) m_miss = (m_miss + 1) % SMOD;
            if (cf) begin
                m_br = (m_br + 1) % SMOD;
                if (hit) begin
                    m_c[i] = ex_taken ? ((m_c[i] < CMAX) ? m_c[i] + 1 : CMAX)
                                      : ((m_c[i] > 0) ? m_c[i] - 1 : 0);
                    if (ex_taken) m_tgt[i] = ex_target;
                    m_j[i] = ex_is_jump;
                end else if (ex_taken) begin
                    m_v[i]   = 1'b1;
                    m_tag[i] = ex_pc >> (IDX_W + 2);
                    m_tgt[i] = ex_target;
                    m_j[i]   = ex_is_jump;
                    m_c[i]   = CHALF;
                end
            end else if (hit) begin
                m_v[i] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [31:0] pc);
        rst = 1'b0; en = 1'b1; if_pc = pc;
        ex_valid = 1'b0; ex_is_br = 1'b0; ex_is_jump = 1'b0; ex_taken = 1'b0;
        ex_pc = 32'h0; ex_target = 32'h0; ex_pred_taken = 1'b0; ex_pred_target = 32'h4;
    endtask

    task automatic resolve(input logic [31:0] pc, input bit br, input bit jmp, input bit tk,
                           input logic [31:0] tgt, input bit pt, input logic [31:0] ptgt);
        ex_valid = 1'b1; ex_pc = pc; ex_is_br = br; ex_is_jump = jmp; ex_taken = tk;
        ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
    endtask

    logic [31:0] pool  [12];
    int          ptype [12];   // 0 branch, 1 jump, 2 other
    logic [31:0] tgts  [5];

    initial begin
        pool = '{32'h100, 32'h140, 32'h180, 32'h104, 32'h200, 32'h240,
                 32'h1000, 32'h1004, 32'hFFFF_FFFC, 32'h3C, 32'h7C, 32'h13C};
        ptype = '{0, 0, 1, 2, 1, 2, 0, 0, 0, 1, 2, 0};
        tgts  = '{32'h80, 32'h400, 32'h500, 32'h0, 32'h1234};

        idle(32'h100);
        rst = 1'b1;
        m_reset();
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b0;

        // Reset state.
        idle(32'h100); #1;
        check("rst_pred_taken", 32'(pred_taken), 32'h0);
        check("rst_pred_target", pred_target, 32'h104);
        check("rst_stats", 32'({stat_br, stat_miss}), 32'h0);
        tick();

        // First taken branch allocates.
        resolve(32'h100, 1, 0, 1, 32'h80, 0, 32'h104); #1;
        check("alloc_mispredict", 32'(mispredict), 32'h1);
        check("alloc_redirect", redirect_pc, 32'h80);
        tick();
        idle(32'h100); #1;
        check("learned_taken", 32'(pred_taken), 32'h1);
        check("learned_target", pred_target, 32'h80);
        check("learned_miss_cnt", 32'(stat_miss), 32'h1);
        tick();

        // Two not-taken resolves, both predicted taken.
        idle(32'h100); resolve(32'h100, 1, 0, 0, 32'h80, 1, 32'h80); tick();
        idle(32'h100); resolve(32'h100, 1, 0, 0, 32'h80, 1, 32'h80); #1;
        check("nt_mispredict", 32'(mispredict), 32'h1);
        check("nt_redirect", redirect_pc, 32'h104);
        tick();
        idle(32'h100); #1;
        check("nt_pred_off", 32'(pred_taken), 32'h0);
        tick();

        // Jump: train, confirm, then retarget.
        idle(32'h200); resolve(32'h200, 0, 1, 1, 32'h400, 0, 32'h204); tick();
        idle(32'h200); resolve(32'h200, 0, 1, 1, 32'h400, 1, 32'h400); #1;
        check("jal_pred", 32'(pred_taken), 32'h1);
        check("jal_hit_ok", 32'(mispredict), 32'h0);
        tick();
        idle(32'h200); resolve(32'h200, 0, 1, 1, 32'h500, 1, 32'h400); #1;
        check("jal_retarget_mp", 32'(mispredict), 32'h1);
        tick();
        idle(32'h200); #1;
        check("jal_new_target", pred_target, 32'h500);
        tick();

        // Tag alias and non-branch invalidate.
        idle(32'h100); resolve(32'h100, 1, 0, 1, 32'h80, 0, 32'h104); tick();
        idle(32'h140); #1;
        check("alias_tag_miss", 32'(pred_taken), 32'h0);
        tick();
        idle(32'h100); resolve(32'h100, 0, 0, 0, 32'h0, 1, 32'h80); #1;
        check("alias_mispredict", 32'(mispredict), 32'h1);
        tick();
        idle(32'h100); #1;
        check("alias_cleared", 32'(pred_taken), 32'h0);
        tick();

        // en=0: outputs still track the inputs, but the state holds.
        idle(32'h300); en = 1'b0; resolve(32'h300, 1, 0, 1, 32'h80, 0, 32'h304); #1;
        check("en0_mispredict", 32'(mispredict), 32'h1);
        tick();
        idle(32'h300); #1;
        check("en0_no_learn", 32'(pred_taken), 32'h0);
        tick();

        // Reset in the middle of training.
        idle(32'h200); resolve(32'h200, 0, 1, 1, 32'h400, 0, 32'h204); tick();
        idle(32'h200); tick();
        idle(32'h200); rst = 1'b1; tick();
        idle(32'h200); #1;
        check("midrst_pred", 32'(pred_taken), 32'h0);
        check("midrst_stat_br", 32'(stat_br), 32'h0);
        tick();

        // stat_br wraps.
        for (int k = 0; k < 16; k++) begin
            idle(32'h400); resolve(32'h400, 1, 0, 0, 32'h0, 0, 32'h404); tick();
        end
        idle(32'h400); #1;
        check("stat_wrap", 32'(stat_br), 32'h0);
        resolve(32'h400, 1, 0, 0, 32'h0, 0, 32'h404);
        tick();

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            int e, t;
            idle(pool[$urandom_range(0, 11)]);
            rst = ($urandom_range(0, 99) == 0);
            en  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 4) != 0) begin
                e = $urandom_range(0, 11);
                t = ptype[e];
                ex_valid   = 1'b1;
                ex_pc      = pool[e];
                ex_is_br   = (t == 0);
                ex_is_jump = (t == 1);
                ex_taken   = (t == 1) ? 1'b1 : (t == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                ex_target  = tgts[$urandom_range(0, 4)];
                if ($urandom_range(0, 4) != 0) begin
                    ex_pred_taken  = m_pred(ex_pc);
                    ex_pred_target = m_pred_tgt(ex_pc);
                end else begin
                    ex_pred_taken  = 1'($urandom_range(0, 1));
                    ex_pred_target = tgts[$urandom_range(0, 4)];
                end
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
